// File: rtl/path_tracer.sv
// path_tracer: walks a predecessor table from destination back to source and
// streams the visited nodes over a valid/ready interface.
// A predecessor entry of all ones marks an unvisited node.
// Build option: define PATH_TRACER_REVERSE_EN to buffer the walk in an internal
// stack and emit the path source-to-destination instead of destination-to-source.
module path_tracer #(
  parameter int MAX_NODES   = 8,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [INDEX_WIDTH-1:0]           source,
  input  logic [INDEX_WIDTH-1:0]           destination,
  input  logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened,
  output logic [INDEX_WIDTH-1:0]           path_node,
  output logic                             path_valid,
  input  logic                             path_ready,
  output logic                             path_last,
  output logic                             busy,
  output logic                             done,
  output logic                             fail,
  output logic [INDEX_WIDTH-1:0]           path_length
);

  // Hop counter must be able to hold MAX_NODES itself.
  localparam int                     HOP_W     = $clog2(MAX_NODES + 1);
  localparam logic [INDEX_WIDTH-1:0] UNVISITED = '1;
  localparam logic [HOP_W-1:0]       HOP_LAST  = HOP_W'(MAX_NODES - 1);

`ifdef PATH_TRACER_REVERSE_EN
  typedef enum logic [2:0] {ST_IDLE, ST_WALK, ST_DRAIN, ST_DONE, ST_FAIL} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_WALK, ST_DONE, ST_FAIL} state_t;
`endif

  state_t                 state;
  logic [INDEX_WIDTH-1:0] cur;
  logic [INDEX_WIDTH-1:0] source_q;
  logic [INDEX_WIDTH-1:0] prev_of_cur;
  logic [HOP_W-1:0]       hop;
  logic                   cur_in_range;

  function automatic logic in_range(input logic [INDEX_WIDTH-1:0] n);
    return 32'(n) < 32'(MAX_NODES);
  endfunction

  // Look up the predecessor of the current node straight from the live table.
  always_comb begin
    // NOTE: default first so every path assigns prev_of_cur and no latch is inferred.
    prev_of_cur = '0;
    for (int j = 0; j < MAX_NODES; j++) begin
      if (32'(cur) == 32'(j)) prev_of_cur = prev_vector_flattened[INDEX_WIDTH*j +: INDEX_WIDTH];
    end
  end

  assign cur_in_range = in_range(cur);

`ifdef PATH_TRACER_REVERSE_EN
  localparam int SEL_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

  logic [INDEX_WIDTH-1:0] stack_mem [MAX_NODES];
  logic [HOP_W-1:0]       sp;
  logic [HOP_W-1:0]       sp_m1;
  logic                   push;

  assign sp_m1 = sp - 1'b1;
  // The source node is never pushed: it goes straight to path_node as the first pop.
  assign push  = (state == ST_WALK) && cur_in_range && (cur != source_q);

  // Stack storage: one write per walk step, asynchronous read at sp-1.
  always_ff @(posedge clock) begin
    // NOTE: storage is deliberately not reset; sp alone decides which entries are live.
    if (push) stack_mem[sp[SEL_W-1:0]] <= cur;
  end
`else
  // The node under inspection is the node on offer.
  assign path_node = cur;
`endif

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cur         <= '0;
      source_q    <= '0;
      hop         <= '0;
      path_valid  <= 1'b0;
      path_last   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      path_length <= '0;
`ifdef PATH_TRACER_REVERSE_EN
      path_node   <= '0;
      sp          <= '0;
`endif
    end else begin
      // NOTE: non-blocking defaults here are overridden by later <= in the same
      // cycle, which makes done/fail single-cycle pulses without extra logic.
      done <= 1'b0;
      fail <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            source_q    <= source;
            cur         <= destination;
            hop         <= '0;
            path_length <= '0;
            busy        <= 1'b1;
            state       <= ST_WALK;
`ifdef PATH_TRACER_REVERSE_EN
            sp          <= '0;
`else
            // Offer the destination node on the very next cycle.
            path_valid  <= in_range(destination);
            path_last   <= in_range(destination) && (destination == source);
`endif
          end
        end

`ifdef PATH_TRACER_REVERSE_EN
        ST_WALK: begin
          if (!cur_in_range) begin
            state <= ST_FAIL;
            fail  <= 1'b1;
          end else begin
            hop <= hop + 1'b1;
            if (cur == source_q) begin
              state      <= ST_DRAIN;
              path_node  <= cur;
              path_valid <= 1'b1;
              path_last  <= (sp == '0);
            end else if ((prev_of_cur == UNVISITED) || (hop == HOP_LAST)) begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end else begin
              sp  <= sp + 1'b1;
              cur <= prev_of_cur;
            end
          end
        end

        ST_DRAIN: begin
          if (path_ready) begin
            if (path_last) begin
              state       <= ST_DONE;
              done        <= 1'b1;
              path_valid  <= 1'b0;
              path_last   <= 1'b0;
              path_length <= INDEX_WIDTH'(hop);
            end else begin
              path_node <= stack_mem[sp_m1[SEL_W-1:0]];
              sp        <= sp_m1;
              path_last <= (sp_m1 == '0);
            end
          end
        end
`else
        ST_WALK: begin
          if (!cur_in_range) begin
            state      <= ST_FAIL;
            fail       <= 1'b1;
            path_valid <= 1'b0;
            path_last  <= 1'b0;
          end else if (path_ready) begin
            // path_valid is necessarily high here: it mirrors cur_in_range in WALK.
            hop        <= hop + 1'b1;
            path_valid <= 1'b0;
            path_last  <= 1'b0;
            if (cur == source_q) begin
              state       <= ST_DONE;
              done        <= 1'b1;
              path_length <= INDEX_WIDTH'(hop + 1'b1);
            end else if ((prev_of_cur == UNVISITED) || (hop == HOP_LAST)) begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end else begin
              cur        <= prev_of_cur;
              path_valid <= in_range(prev_of_cur);
              path_last  <= in_range(prev_of_cur) && (prev_of_cur == source_q);
            end
          end
        end
`endif

        ST_DONE, ST_FAIL: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
